fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Read-side companion to the FPGA FIFO (`fpga_fifo_v3`). It drains a first-word-fall-through FIFO through its `empty`/`pop`/`data` port and presents the data as an AXI4-Stream master, splitting the stream into fixed-length packets marked with `tlast`. A two-entry output stage decouples `pop_o` from `m_axis_tready_i`, so there is no combinational path between the two, and the block sustains one beat per cycle.

## Interface
- `DATA_WIDTH`, 32: width of the FIFO data and of `tdata`.
- `BURST_LEN`, 16: beats per packet, legal range 1..65535.
- `USAGE_WIDTH`, 5: width of `usage_i`, equal to the FIFO's AddrDepth+1.
- `WAIT_FULL_BURST`, 0: when 1, a packet starts only once `usage_i >= BURST_LEN`.

Ports:
- `clk_i` in 1: single clock; every register updates on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `flush_i` in 1: synchronous abort; takes effect the same way as `rst_i`.
- `empty_i` in 1: FIFO empty flag.
- `usage_i` in USAGE_WIDTH: FIFO fill level.
- `data_i` in DATA_WIDTH: FIFO head word; valid whenever `!empty_i`.
- `pop_o` out 1: FIFO pop; consumes `data_i` in the same cycle.
- `m_axis_tvalid_o` out 1: AXI-Stream valid.
- `m_axis_tready_i` in 1: AXI-Stream ready.
- `m_axis_tdata_o` out DATA_WIDTH: AXI-Stream data.
- `m_axis_tlast_o` out 1: marks the last beat of a packet.
- `busy_o` out 1: high when the FSM is in STREAM or the output stage is not empty.
- `pkt_cnt_o` out 16: count of completed packets, wrapping modulo 2^16.

## Operation
**FSM states.** The FSM has two states, IDLE and STREAM.
- IDLE -> STREAM when the start condition holds:
  - `!empty_i` if `WAIT_FULL_BURST`=0;
  - `usage_i >= BURST_LEN` if `WAIT_FULL_BURST`=1.
- STREAM -> IDLE in the cycle the last beat of a packet is popped.
- No pop occurs in IDLE; the first pop happens the cycle after entry into STREAM.

**Pop rule.**
- `pop_o = (state==STREAM) && !empty_i && (occ_q < 2) && !flush_i && !rst_i`.
- `occ_q` is the registered occupancy (0..2) of the output stage.

**Beat counter.**
- `beat_q` is 16 bits, counts pops within the current packet and is cleared on entry to STREAM.
- A pop with `beat_q == BURST_LEN-1` tags that entry last=1 and clears `beat_q`.

**Output stage.**
- It is a two-entry FIFO holding {data, last}.
- `tvalid = (occ_q != 0)`; `tdata`/`tlast` come from the head entry.
- Occupancy next value: `occ_d = occ_q + pop_o - (tvalid && tready)`.
- `tdata` and `tlast` are held stable while `tvalid && !tready` (AXI rule).

**Packet counter.** `pkt_cnt_o` increments on each handshake with `tlast`=1, wrapping 0xFFFF -> 0.

**Flush and reset.**
- `flush_i` or `rst_i` clears: state to IDLE, `occ_q`, `beat_q` and the stage contents.
- `rst_i` also clears `pkt_cnt_o`; `flush_i` does not.
- Any partial packet is discarded and `tvalid` drops without a handshake; this is a documented abort.
- The FIFO's own flush is the system's responsibility.

**Illegal settings.** `BURST_LEN`=0 is illegal; an elaboration-time assertion catches it.

## Timing
- Reset values: `pop_o`=0, `tvalid`=0, `tdata`=0, `tlast`=0, `busy_o`=0, `pkt_cnt_o`=0.
- Latency:
  - start condition true in cycle N -> STREAM in N+1;
  - first `pop_o` in N+1;
  - first `tvalid` in N+2.
- Word popped in cycle K is visible on `tdata` no earlier than K+1.
- `pop_o` depends only on registered state, `empty_i`, `flush_i` and `rst_i`; it never depends on `tready`.
- Throughput: with `tready` held at 1 and the FIFO non-empty, `occ_q` settles at 1 and one beat per cycle flows.
  - Exception: there is one idle pop cycle between packets, caused by the IDLE re-entry.
- Backpressure: with `tready`=0, at most 2 further pops occur; `pop_o` then stays 0 until a handshake frees an entry.
- FIFO empty mid-packet: STREAM is held with `beat_q` preserved; the packet resumes when the FIFO refills.
- A pop and a handshake in the same cycle with `occ_q`=2 is impossible, because `pop_o`=0 when `occ_q`=2.
- A pop and a handshake in the same cycle with `occ_q`=1 leaves `occ_q` at 1.
- `flush_i` and `rst_i` asserted together behave as `rst_i`.

## Test plan
- **Single packet.** Reset 2 cycles, `BURST_LEN`=16, FIFO pre-loaded with 0xA0..0xAF, `tready`=1.
  - Required: 16 beats 0xA0..0xAF in order with no gaps; `tlast` only on 0xAF; `pkt_cnt_o`=1; `busy_o`=0 afterwards.
- **Backpressure.** `tready`=0 for 10 cycles after first valid, then 1.
  - Required: exactly 2 pops while stalled; `tdata` held at 0xA0; all 16 beats delivered in order with no loss or duplication.
- **Random ready.** `tready` toggled randomly over 32 words 0xA0..0xBF with `BURST_LEN`=8.
  - Required: 4 packets with `tlast` on 0xA7, 0xAF, 0xB7, 0xBF; `pkt_cnt_o`=4.
- **Wait for full burst.** `WAIT_FULL_BURST`=1, `BURST_LEN`=4; push 3 words.
  - Required: `pop_o` stays 0.
  - Push a 4th word: STREAM is entered the next cycle and 4 beats go out with `tlast` on the 4th.
- **Empty mid-packet.** `BURST_LEN`=8; push 5 words, wait 6 cycles, push 3 more.
  - Required: a single packet of 8 beats with `tlast` only on beat 8.
- **Flush mid-packet.** `flush_i` pulsed for 1 cycle after beat 3 of 16.
  - Required: next cycle `tvalid`=0, FSM in IDLE, `pkt_cnt_o` unchanged.
  - The next packet counts beats from 1 and asserts `tlast` on its own 16th beat.

Source files
------------

// File: rtl/fifo_axis_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_reader_if
//  Description : AXI4-Stream bus bundle (tvalid/tready/tdata/tlast) with
//                master and slave views.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_axis_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_axis_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_reader
//  Description : Drains a first-word-fall-through FIFO and presents it as an
//                AXI4-Stream master cut into BURST_LEN-beat packets. A
//                two-entry output stage keeps pop_o independent of tready.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_axis_reader #(
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN       = 16,
    parameter int USAGE_WIDTH     = 5,
    parameter int WAIT_FULL_BURST = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   empty_i,
    input  logic [USAGE_WIDTH-1:0] usage_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic                   pop_o,
    fifo_axis_reader_if.master     m_axis,
    output logic                   busy_o,
    output logic [15:0]            pkt_cnt_o
);

    // A zero-length packet has no last beat, so the stream could never close.
    generate
        if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_burst_len
            $error("fifo_axis_reader: BURST_LEN must be within 1..65535");
        end
    endgenerate

    localparam logic [15:0] c_LAST_BEAT = 16'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                      state_q,   state_d;
    logic [15:0]                 beat_q,    beat_d;
    logic [1:0]                  occ_q,     occ_d;
    logic                        wr_ptr_q,  wr_ptr_d;
    logic                        rd_ptr_q,  rd_ptr_d;
    logic [1:0][DATA_WIDTH:0]    mem_q,     mem_d;      // {last, data}
    logic [15:0]                 pkt_cnt_q, pkt_cnt_d;

    logic w_start;
    logic w_pop;
    logic w_hs;
    logic w_last_beat;
    logic w_head_last;

    // Start condition: either any data, or a whole packet already buffered.
    assign w_start = (WAIT_FULL_BURST != 0) ? (32'(usage_i) >= 32'(BURST_LEN))
                                            : !empty_i;

    // Pop looks only at registered state and the FIFO flag, never at tready.
    assign w_pop       = (state_q == ST_STREAM) && !empty_i && (occ_q < 2'd2)
                         && !flush_i && !rst_i;
    assign w_hs        = (occ_q != 2'd0) && m_axis.tready;
    assign w_last_beat = (beat_q == c_LAST_BEAT);
    assign w_head_last = mem_q[rd_ptr_q][DATA_WIDTH];

    assign pop_o         = w_pop;
    assign m_axis.tvalid = (occ_q != 2'd0);
    assign m_axis.tdata  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign m_axis.tlast  = w_head_last;
    assign busy_o        = (state_q == ST_STREAM) || (occ_q != 2'd0);
    assign pkt_cnt_o     = pkt_cnt_q;

    // Next-state for the FSM, beat counter, output stage and packet counter.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        occ_d     = occ_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;
        pkt_cnt_d = pkt_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_STREAM;
                    beat_d  = 16'd0;
                end
            end
            ST_STREAM: begin
                if (w_pop) begin
                    if (w_last_beat) begin
                        beat_d  = 16'd0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_pop) begin
            mem_d[wr_ptr_q] = {w_last_beat, data_i};
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (w_hs) begin
            rd_ptr_d = ~rd_ptr_q;
            if (w_head_last) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        case ({w_pop, w_hs})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // Abort: the partial packet in flight is dropped without handshake.
        if (flush_i) begin
            state_d  = ST_IDLE;
            beat_d   = 16'd0;
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            mem_d    = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            beat_q    <= 16'd0;
            occ_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            mem_q     <= '0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            occ_q     <= occ_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_axis_reader
//  Description : Bench for fifo_axis_reader. Three instances cover
//                BURST_LEN 16, BURST_LEN 8 and BURST_LEN 4 with
//                WAIT_FULL_BURST=1. A FIFO model feeds each instance; a
//                stream model predicts every delivered beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_axis_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            flush;
    logic [2:0]      tready;
    logic [2:0]      empty_w, pop_w, tvalid_w, tlast_w, busy_w;
    logic [2:0][6:0] usage_w;
    logic [2:0][31:0] data_w, tdata_w;
    logic [2:0][15:0] pkt_w;

    // FIFO model: every pushed word stays in fmem, so fmem is also the
    // ordered list of words the stream has to deliver.
    logic [31:0] fmem [3][64];
    int          fhead [3];
    int          ftail [3];

    // Stream model state.
    int          dcnt  [3];   // index of next word expected on tdata
    int          pos   [3];   // beat position inside current packet
    logic [15:0] pcnt  [3];   // expected completed packets
    int          occ_m [3];   // pops minus handshakes since last abort
    bit          stall_q [3];
    logic [31:0] stall_d [3];
    logic        stall_l [3];

    // Captured handshakes.
    logic [31:0] cap_d [3][64];
    bit          cap_l [3][64];
    int          cap_c [3][64];
    int          ncap  [3];

    int cyc;
    bit armed;
    int cmp_cnt;
    int err_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cfg
            fifo_axis_reader_if #(.DATA_WIDTH(32)) axis ();
            assign axis.tready  = tready[gi];
            assign tvalid_w[gi] = axis.tvalid;
            assign tdata_w[gi]  = axis.tdata;
            assign tlast_w[gi]  = axis.tlast;
            assign empty_w[gi]  = (fhead[gi] == ftail[gi]);
            assign usage_w[gi]  = 7'(ftail[gi] - fhead[gi]);
            assign data_w[gi]   = fmem[gi][fhead[gi] & 63];

            fifo_axis_reader #(
                .DATA_WIDTH      (32),
                .BURST_LEN       ((gi == 0) ? 16 : ((gi == 1) ? 8 : 4)),
                .USAGE_WIDTH     (7),
                .WAIT_FULL_BURST ((gi == 2) ? 1 : 0)
            ) u_dut (
                .clk_i     (clk),
                .rst_i     (rst),
                .flush_i   (flush),
                .empty_i   (empty_w[gi]),
                .usage_i   (usage_w[gi]),
                .data_i    (data_w[gi]),
                .pop_o     (pop_w[gi]),
                .m_axis    (axis),
                .busy_o    (busy_w[gi]),
                .pkt_cnt_o (pkt_w[gi])
            );
        end
    endgenerate

    function automatic int bl(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 8 : 4);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s[%0d]: actual %h required %h (cycle %0d)",
                     nm, idx, act, exp, cyc);
        end
    endtask

    // FIFO read side and cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst)           fhead[i] <= 0;
            else if (pop_w[i]) fhead[i] <= fhead[i] + 1;
        end
    end

    // Per-cycle compare against the stream model, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic hs;
            hs = tvalid_w[i] && tready[i];
            if (armed) begin
                chk("pkt_cnt", i, pkt_w[i], pcnt[i]);
                chk("tvalid_vs_occ", i, tvalid_w[i], occ_m[i] != 0);
                if (pop_w[i]) begin
                    chk("pop_room", i, occ_m[i] < 2, 1);
                    chk("pop_nonempty", i, empty_w[i], 0);
                end
                if (stall_q[i]) begin
                    chk("hold_valid", i, tvalid_w[i], 1);
                    chk("hold_data", i, tdata_w[i], stall_d[i]);
                    chk("hold_last", i, tlast_w[i], stall_l[i]);
                end
                if (hs) begin
                    chk("tdata", i, tdata_w[i], fmem[i][dcnt[i] & 63]);
                    chk("tlast", i, tlast_w[i], pos[i] == bl(i) - 1);
                end
            end
            if (hs) begin
                if (ncap[i] < 64) begin
                    cap_d[i][ncap[i]] = tdata_w[i];
                    cap_l[i][ncap[i]] = tlast_w[i];
                    cap_c[i][ncap[i]] = cyc;
                end
                ncap[i]++;
                dcnt[i]++;
                if (pos[i] == bl(i) - 1) begin
                    pos[i]  = 0;
                    pcnt[i] = pcnt[i] + 16'd1;
                end else begin
                    pos[i]++;
                end
            end
            occ_m[i]   = occ_m[i] + (pop_w[i] ? 1 : 0) - (hs ? 1 : 0);
            stall_q[i] = tvalid_w[i] && !tready[i];
            stall_d[i] = tdata_w[i];
            stall_l[i] = tlast_w[i];
            if (rst) begin
                occ_m[i] = 0; pos[i] = 0; dcnt[i] = 0; pcnt[i] = 16'd0;
                ncap[i] = 0; stall_q[i] = 1'b0;
            end else if (flush) begin
                occ_m[i] = 0; pos[i] = 0; dcnt[i] = fhead[i]; stall_q[i] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [31:0] v);
        fmem[i][ftail[i] & 63] = v;
        ftail[i]++;
    endtask

    task automatic do_reset();
        tready = '0;
        flush  = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) ftail[i] = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int i, input int n, input int budget);
        int t;
        t = 0;
        while (ncap[i] < n && t < budget) begin
            tick();
            t++;
        end
        chk("beats_timeout", i, ncap[i] >= n, 1);
    endtask

    function automatic int count_last(input int i, input int lo, input int hi);
        int c;
        c = 0;
        for (int k = lo; k <= hi; k++) if (cap_l[i][k]) c++;
        return c;
    endfunction

    initial begin
        int t;
        cmp_cnt = 0; err_cnt = 0; cyc = 0; armed = 1'b0;
        rst = 1'b1; flush = 1'b0; tready = '0;
        for (int i = 0; i < 3; i++) begin
            fhead[i] = 0; ftail[i] = 0; ncap[i] = 0;
        end

        // Reset values.
        do_reset();
        armed = 1'b1;
        chk("rst_pop", 0, pop_w[0], 0);
        chk("rst_tvalid", 0, tvalid_w[0], 0);
        chk("rst_tdata", 0, tdata_w[0], 0);
        chk("rst_tlast", 0, tlast_w[0], 0);
        chk("rst_busy", 0, busy_w[0], 0);
        chk("rst_pkt", 0, pkt_w[0], 0);

        // Single packet with exact start latency.
        tready[0] = 1'b1;
        for (int k = 0; k < 16; k++) push(0, 32'hA0 + k);
        #1;
        chk("t1_pop_n", 0, pop_w[0], 0);
        tick();
        chk("t1_pop_n1", 0, pop_w[0], 1);
        chk("t1_valid_n1", 0, tvalid_w[0], 0);
        tick();
        chk("t1_valid_n2", 0, tvalid_w[0], 1);
        chk("t1_data_n2", 0, tdata_w[0], 32'hA0);
        wait_beats(0, 16, 100);
        repeat (3) tick();
        chk("t1_first", 0, cap_d[0][0], 32'hA0);
        chk("t1_lastword", 0, cap_d[0][15], 32'hAF);
        chk("t1_nogap", 0, cap_c[0][15] - cap_c[0][0], 15);
        chk("t1_tlast_pos", 0, cap_l[0][15], 1);
        chk("t1_tlast_cnt", 0, count_last(0, 0, 15), 1);
        chk("t1_ncap", 0, ncap[0], 16);
        chk("t1_pkt", 0, pkt_w[0], 1);
        chk("t1_busy", 0, busy_w[0], 0);

        // Backpressure: two pops while stalled, head word held.
        do_reset();
        for (int k = 0; k < 16; k++) push(0, 32'hA0 + k);
        t = 0;
        while (!tvalid_w[0] && t < 20) begin tick(); t++; end
        chk("t2_valid_seen", 0, tvalid_w[0], 1);
        repeat (10) tick();
        chk("t2_pops_stalled", 0, fhead[0], 2);
        chk("t2_pop_blocked", 0, pop_w[0], 0);
        chk("t2_hold", 0, tdata_w[0], 32'hA0);
        tready[0] = 1'b1;
        wait_beats(0, 16, 100);
        repeat (5) tick();
        chk("t2_ncap", 0, ncap[0], 16);
        chk("t2_second", 0, cap_d[0][1], 32'hA1);
        chk("t2_lastword", 0, cap_d[0][15], 32'hAF);
        chk("t2_pkt", 0, pkt_w[0], 1);

        // Random ready, four packets of 8.
        do_reset();
        for (int k = 0; k < 32; k++) push(1, 32'hA0 + k);
        t = 0;
        while (ncap[1] < 32 && t < 400) begin
            tready[1] = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        chk("t3_done", 1, ncap[1] >= 32, 1);
        tready[1] = 1'b1;
        repeat (4) tick();
        chk("t3_tlast_cnt", 1, count_last(1, 0, 31), 4);
        for (int j = 0; j < 4; j++) begin
            chk("t3_last_flag", 1, cap_l[1][8*j+7], 1);
            chk("t3_last_data", 1, cap_d[1][8*j+7], 32'hA7 + 8*j);
        end
        chk("t3_pkt", 1, pkt_w[1], 4);

        // Wait for full burst (BURST_LEN 4).
        do_reset();
        tready[2] = 1'b1;
        for (int k = 0; k < 3; k++) push(2, 32'hA0 + k);
        repeat (6) begin
            tick();
            chk("t4_no_pop", 2, pop_w[2], 0);
        end
        chk("t4_fhead", 2, fhead[2], 0);
        push(2, 32'hA3);
        #1;
        chk("t4_pop_n", 2, pop_w[2], 0);
        tick();
        chk("t4_pop_n1", 2, pop_w[2], 1);
        wait_beats(2, 4, 40);
        repeat (3) tick();
        chk("t4_ncap", 2, ncap[2], 4);
        chk("t4_tlast_pos", 2, cap_l[2][3], 1);
        chk("t4_tlast_cnt", 2, count_last(2, 0, 3), 1);
        chk("t4_lastword", 2, cap_d[2][3], 32'hA3);
        chk("t4_pkt", 2, pkt_w[2], 1);

        // FIFO empty mid-packet.
        do_reset();
        tready[1] = 1'b1;
        for (int k = 0; k < 5; k++) push(1, 32'hC0 + k);
        repeat (8) tick();
        chk("t5_partial", 1, ncap[1], 5);
        chk("t5_busy_gap", 1, busy_w[1], 1);
        chk("t5_valid_gap", 1, tvalid_w[1], 0);
        for (int k = 5; k < 8; k++) push(1, 32'hC0 + k);
        wait_beats(1, 8, 40);
        repeat (3) tick();
        chk("t5_tlast_pos", 1, cap_l[1][7], 1);
        chk("t5_tlast_cnt", 1, count_last(1, 0, 7), 1);
        chk("t5_lastword", 1, cap_d[1][7], 32'hC7);
        chk("t5_pkt", 1, pkt_w[1], 1);
        chk("t5_busy_end", 1, busy_w[1], 0);

        // Flush after beat 3 of 16.
        do_reset();
        tready[0] = 1'b1;
        for (int k = 0; k < 16; k++) push(0, 32'hD0 + k);
        wait_beats(0, 3, 40);
        flush     = 1'b1;
        tready[0] = 1'b0;
        tick();
        flush = 1'b0;
        chk("t6_valid_drop", 0, tvalid_w[0], 0);
        chk("t6_idle", 0, busy_w[0], 0);
        chk("t6_pkt_kept", 0, pkt_w[0], 0);
        for (int k = 0; k < 16; k++) push(0, 32'hE0 + k);
        tready[0] = 1'b1;
        wait_beats(0, 19, 120);
        repeat (2) tick();
        chk("t6_resume", 0, cap_d[0][3], 32'hD4);
        chk("t6_16th", 0, cap_d[0][18], 32'hE3);
        chk("t6_tlast_pos", 0, cap_l[0][18], 1);
        chk("t6_tlast_cnt", 0, count_last(0, 3, 18), 1);
        chk("t6_pkt", 0, pkt_w[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
